// File: rtl/seq_adder16_pkg.sv
// Shared constants, state encoding and full-adder helper for the
// multi-cycle 16-bit adder.
package seq_adder_pkg;

    localparam int N         = 16;
    localparam int W         = 4;
    localparam int S         = N / W;
    localparam int IDX_W     = (S > 1) ? $clog2(S) : 1;
    localparam int LAST_IDX  = S - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // One-bit full adder; returns {carry_out, sum}.
    function automatic logic [1:0] full_add(
        input logic a,
        input logic b,
        input logic c
    );
        logic s;
        logic co;
        s  = a ^ b ^ c;
        co = (a & b) | (c & (a ^ b));
        return {co, s};
    endfunction

endpackage

// File: rtl/seq_adder16_if.sv
// Operand and result handshakes of seq_adder16 bundled in one interface.
// "master" is the producer/consumer side, "slave" is the adder itself.
interface seq_adder16_if;
    import seq_adder_pkg::*;

    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] inp1;
    logic [N-1:0] inp2;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         co;
    logic         ovf;

    modport master (
        output in_valid,
        output inp1,
        output inp2,
        output cin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  co,
        input  ovf
    );

    modport slave (
        input  in_valid,
        input  inp1,
        input  inp2,
        input  cin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output co,
        output ovf
    );
endinterface

// File: rtl/seq_adder16_a4bitadd.sv
// W-bit ripple-carry slice built from full adders. The carry into the top
// bit is exported so the caller can derive signed overflow.
module a4bitadd
    import seq_adder_pkg::*;
(
    input  logic [W-1:0] inp1,
    input  logic [W-1:0] inp2,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         co,
    output logic         c_msb_in
);

    logic [W:0] carry_s;

    assign carry_s[0] = cin;

    genvar i;
    generate
        for (i = 0; i < W; i++) begin : g_fa
            logic [1:0] fa_s;
            assign fa_s         = full_add(inp1[i], inp2[i], carry_s[i]);
            assign sum[i]       = fa_s[0];
            assign carry_s[i+1] = fa_s[1];
        end
    endgenerate

    assign co       = carry_s[W];
    assign c_msb_in = carry_s[W-1];

endmodule

// File: rtl/seq_adder16.sv
// Multi-cycle adder: accepts operands over a valid/ready handshake, adds one
// W-bit slice per cycle through a single shared slice adder, and returns
// sum, carry-out and signed overflow over a second valid/ready handshake.
module seq_adder16 (
    input  logic         clk,
    input  logic         rst_n,
    seq_adder16_if.slave bus
);
    import seq_adder_pkg::*;

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic [N-1:0]       a_q;
    logic [N-1:0]       a_d;
    logic [N-1:0]       b_q;
    logic [N-1:0]       b_d;
    logic [N-1:0]       sum_q;
    logic [N-1:0]       sum_d;
    logic               carry_q;
    logic               carry_d;
    logic               co_q;
    logic               co_d;
    logic               ovf_q;
    logic               ovf_d;

    logic [W-1:0]       slice_a_s;
    logic [W-1:0]       slice_b_s;
    logic [W-1:0]       slice_sum_s;
    logic               slice_co_s;
    logic               slice_cmsb_s;
    logic               last_s;

    // Operand slice currently being added is selected by the slice index.
    assign slice_a_s = a_q[int'(idx_q)*W +: W];
    assign slice_b_s = b_q[int'(idx_q)*W +: W];
    assign last_s    = (idx_q == IDX_W'(LAST_IDX));

    a4bitadd u_slice (
        .inp1     (slice_a_s),
        .inp2     (slice_b_s),
        .cin      (carry_q),
        .sum      (slice_sum_s),
        .co       (slice_co_s),
        .c_msb_in (slice_cmsb_s)
    );

    // Handshake flags come straight from the state register; results from
    // their own registers, so no input reaches an output combinationally.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.co        = co_q;
    assign bus.ovf       = ovf_q;

    // Next-state and datapath update for the IDLE/BUSY/DONE sequence.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        co_d    = co_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.inp1;
                    b_d     = bus.inp2;
                    carry_d = bus.cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end

            BUSY: begin
                sum_d[int'(idx_q)*W +: W] = slice_sum_s;
                carry_d                    = slice_co_s;
                if (last_s) begin
                    // Overflow: carry into the sign bit differs from carry out.
                    co_d    = slice_co_s;
                    ovf_d   = slice_co_s ^ slice_cmsb_s;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = BUSY;
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Index, operand, carry and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: doc/seq_adder16.md
# seq_adder16

Multi-cycle 16-bit adder, the addition counterpart of the combinational ripple subtractor used in the CPU datapath. It accepts two operands and a carry-in over a valid/ready handshake and adds them one 4-bit slice per cycle through a single reused 4-bit slice adder. It returns sum, carry-out and signed overflow over a second valid/ready handshake. It sits between the ALU operand latches and the writeback mux, wherever area matters more than single-cycle latency.

## Interface
- N, 16, operand width; must be a multiple of W
- W, 4, slice width added per cycle; number of slices S = N/W
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and cin are valid
- in_ready  out  1  block can accept operands; high only in IDLE
- inp1  in  N  augend
- inp2  in  N  addend
- cin  in  1  carry-in
- out_valid  out  1  sum, co and ovf are valid
- out_ready  in  1  consumer accepts the result
- sum  out  N  inp1 + inp2 + cin, modulo 2^N
- co  out  1  unsigned carry-out of bit N-1
- ovf  out  1  two's-complement overflow

## Operation
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- FSM has three states: IDLE, BUSY and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch inp1, inp2 into operand registers; carry_reg<=cin; idx<=0; clear sum register; go to BUSY.
  - in_valid low: stay in IDLE.
- BUSY:
  - Each cycle, slice adder computes a[idx*W+:W] + b[idx*W+:W] + carry_reg.
  - sum[idx*W+:W] <= slice sum; carry_reg <= slice carry-out; idx <= idx+1.
  - When idx==S-1: also capture co and ovf, then go to DONE.
  - in_ready=0. in_valid is ignored, and operands presented during BUSY are not latched.
- DONE:
  - out_valid=1.
  - sum, co and ovf are held stable while out_ready=0.
  - On out_valid&&out_ready: go to IDLE.
- ovf is the carry into bit N-1 XOR the carry out of bit N-1. Both come from the last slice, whose internal bit-(W-2) carry is exported.
- Widths: all arithmetic is unsigned modulo 2^N. idx is ceil(log2 S) bits wide and never exceeds S-1.
- Reset, asynchronous, including mid-operation:
  - State returns to IDLE.
  - in_ready=1, out_valid=0.
  - sum=0, co=0, ovf=0, carry_reg=0, idx=0.
  - Any in-flight operation is discarded without output.

## Timing
- Acceptance edge is T.
- Slice updates occur at edges T+1 … T+S.
- out_valid rises after edge T+S (4 cycles after acceptance at default parameters).
- in_ready and out_valid are decoded from registered state only, with no combinational path from inputs.
- Minimum period between successive acceptances is S+2 cycles: accept, S BUSY cycles, DONE with immediate out_ready, then IDLE.
- out_ready arriving before DONE has no effect.
- Simultaneous out_ready in DONE and in_valid: the result handshake completes this cycle. The new operands are accepted on the following IDLE cycle, not this one.

## Structure
- The shared package (seq_adder_pkg) holds:
  - localparams N, W and S;
  - state enum typedef {IDLE, BUSY, DONE};
  - idx width constant.
- One sub-module, a4bitadd:
  - W-bit ripple adder slice built from full adders, mirroring the subtractor slice hierarchy;
  - ports inp1, inp2, cin, sum, co, plus c_msb_in (carry into its top bit) for overflow detection.
- Top level contains the FSM, idx counter, operand/sum/carry registers and a single a4bitadd instance.

## Test plan
- 0x1234+0x4321, cin=0 -> sum=0x5555, co=0, ovf=0. out_valid is high exactly 4 cycles after the accept edge.
- 0xFFFF+0x0001, cin=0 -> sum=0x0000, co=1, ovf=0 (carry ripples across all four slices). 0x00FF+0x0000, cin=1 -> sum=0x0100.
- 0x7FFF+0x0001 -> sum=0x8000, co=0, ovf=1. 0x8000+0x8000 -> sum=0x0000, co=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> sum, co and ovf stay constant and out_valid stays 1. During the same window, toggle in_valid with new operands -> not latched and in_ready=0.
- Pull rst_n low during the 2nd BUSY cycle -> immediately out_valid=0, in_ready=1, sum=0. The next operation after release completes correctly.
- Randomised back-to-back stream of 1000 operations with random out_ready -> every result matches the reference model (inp1+inp2+cin). No results are dropped or duplicated.
